// File: rtl/ram2video_pkg.sv
// Shared types, helpers and default timing constants for the RAM-to-video scanner.
package ram2video_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // True when start <= v < start+width (signed ints so zero bounds compare cleanly).
    function automatic logic in_win(input int v, input int start, input int width);
        return (v >= start) && (v < start + width);
    endfunction

    // 640x480 @ 60 Hz
    localparam int H_VIS_640 = 640, H_TOT_640 = 800, H_SS_640 = 656, H_SW_640 = 96;
    localparam int V_VIS_480 = 480, V_TOT_480 = 525, V_SS_480 = 490, V_SW_480 = 2;
    // 720x480 @ 60 Hz
    localparam int H_VIS_720 = 720, H_TOT_720 = 858, H_SS_720 = 736, H_SW_720 = 62;
    localparam int V_TOT_720 = 525, V_SS_720 = 489, V_SW_720 = 6;

endpackage

// File: rtl/ram2video_if.sv
// RAM read port, mode controls and video output bundle of the scanner.
interface ram2video_if #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 2
);
    localparam int C_W = DATA_W / 3;

    logic [DATA_W-1:0]    rddata;
    logic                 start;
    logic                 line_repeat;
    logic                 alt_lines;
    logic [SLOT_W-1:0]    wr_line;
    logic [ADDR_BITS-1:0] rdaddr;
    logic [C_W-1:0]       red, green, blue;
    logic                 hsync, vsync, de;
    logic                 frame_start, line_start, underrun;

    modport master (
        output rddata, start, line_repeat, alt_lines, wr_line,
        input  rdaddr, red, green, blue, hsync, vsync, de, frame_start, line_start, underrun
    );

    modport slave (
        input  rddata, start, line_repeat, alt_lines, wr_line,
        output rdaddr, red, green, blue, hsync, vsync, de, frame_start, line_start, underrun
    );
endinterface

// File: rtl/ram2video_delay.sv
// Clearable shift register that carries coordinates alongside the RAM read latency.
module ram2video_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift one stage per clock; a clear flushes every stage so stale
    // coordinates never leak out after the scan stops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   stage <= '0;
        else if (clr) stage <= '0;
        else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/ram2video_gen.sv
// Raster timing generator that fetches pixels from the line-buffer RAM and
// drives aligned RGB, syncs, data-enable and frame/line strobes.
module ram2video_gen import ram2video_pkg::*; #(
    parameter int ADDR_BITS    = 12,
    parameter int DATA_W       = 24,
    parameter int H_VISIBLE    = H_VIS_640,
    parameter int H_TOTAL      = H_TOT_640,
    parameter int H_SYNC_START = H_SS_640,
    parameter int H_SYNC_WIDTH = H_SW_640,
    parameter int V_VISIBLE    = V_VIS_480,
    parameter int V_TOTAL      = V_TOT_480,
    parameter int V_TOTAL_ALT  = V_TOT_480,
    parameter int V_SYNC_START = V_SS_480,
    parameter int V_SYNC_WIDTH = V_SW_480,
    parameter int H_OFFSET     = 0,
    parameter int V_OFFSET     = 0,
    parameter int PIXEL_FACTOR = 1,
    parameter int BUFFER_LINES = 4,
    parameter int RD_LATENCY   = 2,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1
) (
    input  logic      clock,
    input  logic      reset,
    ram2video_if.slave vio
);
    localparam int SLOT_W = clog2(BUFFER_LINES);
    localparam int PX_W   = ADDR_BITS - SLOT_W;
    localparam int C_W    = DATA_W / 3;

    state_t      state, state_nx;
    logic        run, mode_chg, lr_q, al_q, fetch, ur_q, hs_q, vs_q;
    logic [11:0] x, y, vtot, xo, yo, px, sl;
    logic [SLOT_W-1:0] slot;
    logic        v_d;
    logic [11:0] x_d, y_d;
    logic [24:0] d_out;
    logic        de_i, vs_now;

    assign run      = (state == RUN);
    assign mode_chg = (vio.line_repeat != lr_q) || (vio.alt_lines != al_q);
    assign vtot     = al_q ? 12'(V_TOTAL_ALT) : 12'(V_TOTAL);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // A mode change always drops to IDLE, even if start is high that clock.
    always_comb begin
        state_nx = state;
        if (mode_chg)                    state_nx = IDLE;
        else if (!run && vio.start)      state_nx = RUN;
    end

    // Registered copies of the mode inputs, used to detect a change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lr_q <= 1'b0;
            al_q <= 1'b0;
        end else begin
            lr_q <= vio.line_repeat;
            al_q <= vio.alt_lines;
        end
    end

    // Raster counters: held at the origin unless the scan keeps running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (run && state_nx == RUN) begin
            if (x == 12'(H_TOTAL - 1)) begin
                x <= '0;
                y <= (y == vtot - 12'd1) ? 12'd0 : y + 12'd1;
            end else begin
                x <= x + 12'd1;
            end
        end else begin
            x <= '0;
            y <= '0;
        end
    end

    // Fetch window and RAM address from the live counters.
    always_comb begin
        fetch = run && in_win(int'(x), H_OFFSET, H_VISIBLE - 2 * H_OFFSET)
                    && in_win(int'(y), V_OFFSET, V_VISIBLE - 2 * V_OFFSET);
        xo    = x - 12'(H_OFFSET);
        yo    = y - 12'(V_OFFSET);
        px    = (PIXEL_FACTOR == 2) ? (xo >> 1) : xo;
        sl    = lr_q ? (yo >> 1) : yo;
        slot  = SLOT_W'(sl);
    end

    assign vio.rdaddr = fetch ? {slot, PX_W'(px)} : '0;

    // Sticky underrun: reading the slot the writer is filling; only a mode change clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                             ur_q <= 1'b0;
        else if (mode_chg)                      ur_q <= 1'b0;
        else if (fetch && slot == vio.wr_line)  ur_q <= 1'b1;
    end

    assign vio.underrun = ur_q;

    ram2video_delay #(.WIDTH(25), .DEPTH(RD_LATENCY)) u_dly (
        .clock (clock),
        .reset (reset),
        .clr   (!run),
        .din   ({run, x, y}),
        .dout  (d_out)
    );

    assign {v_d, x_d, y_d} = d_out;

    // Delayed coordinates line up with rddata, so de and strobes come from them.
    assign de_i            = run && v_d && (x_d < 12'(H_VISIBLE)) && (y_d < 12'(V_VISIBLE));
    assign vio.de          = de_i;
    assign {vio.red, vio.green, vio.blue} = de_i ? vio.rddata[3*C_W-1:0] : '0;
    assign vio.frame_start = run && v_d && (x_d == 12'd0) && (y_d == 12'd0);
    assign vio.line_start  = run && v_d && (x_d == 12'd0) && (y_d < 12'(V_VISIBLE));

    // vsync edges coincide with the hsync leading edge of the start/end lines.
    assign vs_now = (int'(y_d) == V_SYNC_START && int'(x_d) >= H_SYNC_START)
                 || (int'(y_d) >  V_SYNC_START && int'(y_d) < V_SYNC_START + V_SYNC_WIDTH)
                 || (int'(y_d) == V_SYNC_START + V_SYNC_WIDTH && int'(x_d) < H_SYNC_START);

    // Syncs take one more register stage after the delayed coordinates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || !run) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= v_d && in_win(int'(x_d), H_SYNC_START, H_SYNC_WIDTH);
            vs_q <= v_d && vs_now;
        end
    end

    assign vio.hsync = (run && hs_q) ? HS_POL : ~HS_POL;
    assign vio.vsync = (run && vs_q) ? VS_POL : ~VS_POL;
endmodule

// File: tb/tb_ram2video_gen.sv
// Randomised bench for ram2video_gen with a frame-position reference model and
// an expectation queue drained by an independent monitor.
module tb_ram2video_gen;
    localparam int  HT = 16, HV = 10, HSS = 12, HSW = 2;
    localparam int  VT = 8, VTA = 9, VV = 5, VSS = 6, VSW = 1;
    localparam int  HO = 1, VO = 0, PF = 1, BL = 4, RL = 2, PX_W = 10;
    localparam bit  HS_POL = 1'b1, VS_POL = 1'b0;

    typedef struct packed {
        logic [11:0] rdaddr;
        logic [23:0] rgb;
        logic hs, vs, de, fs, ls, ur;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [11:0] ra1, ra2;
    obs_t exp_q[$];
    int   n_pass = 0, n_tot = 0, force_n = 0;

    // model state: running flag, linear position within the frame, length of
    // the current uninterrupted run, sticky underrun and last seen modes
    bit m_run, m_ur, m_lr, m_al;
    int m_pos, m_len;

    ram2video_if #(.ADDR_BITS(12), .DATA_W(24), .SLOT_W(2)) vio ();

    ram2video_gen #(
        .ADDR_BITS(12), .DATA_W(24), .H_VISIBLE(HV), .H_TOTAL(HT),
        .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW), .V_VISIBLE(VV), .V_TOTAL(VT),
        .V_TOTAL_ALT(VTA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .H_OFFSET(HO), .V_OFFSET(VO), .PIXEL_FACTOR(PF), .BUFFER_LINES(BL),
        .RD_LATENCY(RL), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vio   (vio.slave)
    );

    always #5 clock = ~clock;

    // RAM stand-in: data is the address, returned two clocks later.
    always @(posedge clock) begin
        ra1 <= vio.rdaddr;
        ra2 <= ra1;
    end
    assign vio.rddata = {ra2, ra2};

    function automatic bit fetch_at(int p);
        int x, y;
        x = p % HT;
        y = p / HT;
        return x >= HO && x < HV - HO && y >= VO && y < VV - VO;
    endfunction

    function automatic int slot_at(int p, bit lr);
        int y;
        y = p / HT - VO;
        return (lr ? y / 2 : y) % BL;
    endfunction

    function automatic int addr_at(int p, bit lr);
        if (!fetch_at(p)) return 0;
        return ((slot_at(p, lr) << PX_W) | (((p % HT) - HO) / PF)) & 'hFFF;
    endfunction

    function automatic obs_t expect_now();
        obs_t e;
        int fl, p2, p3;
        bit v2, v3;
        fl = HT * (m_al ? VTA : VT);
        p2 = (m_pos - 2 + fl) % fl;
        p3 = (m_pos - 3 + fl) % fl;
        v2 = m_run && m_len >= 3;
        v3 = m_run && m_len >= 4;
        e.rdaddr = m_run ? 12'(addr_at(m_pos, m_lr)) : 12'd0;
        e.de     = v2 && (p2 % HT) < HV && (p2 / HT) < VV;
        e.rgb    = e.de ? {12'(addr_at(p2, m_lr)), 12'(addr_at(p2, m_lr))} : 24'd0;
        e.fs     = v2 && p2 == 0;
        e.ls     = v2 && (p2 % HT) == 0 && (p2 / HT) < VV;
        e.hs     = (v3 && (p3 % HT) >= HSS && (p3 % HT) < HSS + HSW) ? HS_POL : !HS_POL;
        e.vs     = (v3 && p3 >= VSS * HT + HSS && p3 < (VSS + VSW) * HT + HSS) ? VS_POL : !VS_POL;
        e.ur     = m_ur;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0; m_ur = 0; m_lr = 0; m_al = 0; m_pos = 0; m_len = 0;
    endtask

    // Advance the model across the next clock edge using the inputs now applied.
    task automatic model_step();
        bit chg, nrun;
        int fl;
        chg  = (vio.line_repeat != m_lr) || (vio.alt_lines != m_al);
        nrun = chg ? 1'b0 : (m_run ? 1'b1 : vio.start);
        fl   = HT * (m_al ? VTA : VT);
        if (chg) m_ur = 0;
        else if (m_run && fetch_at(m_pos) && slot_at(m_pos, m_lr) == int'(vio.wr_line)) m_ur = 1;
        m_pos = (m_run && nrun) ? (m_pos + 1) % fl : 0;
        m_len = nrun ? m_len + 1 : 0;
        m_run = nrun;
        m_lr  = vio.line_repeat;
        m_al  = vio.alt_lines;
    endtask

    task automatic check_obs(string name, obs_t e);
        obs_t g;
        g = {vio.rdaddr, vio.red, vio.green, vio.blue, vio.hsync, vio.vsync,
             vio.de, vio.frame_start, vio.line_start, vio.underrun};
        n_tot++;
        if (g === e) n_pass++;
        else $display("FAIL %s t=%0t got addr=%h rgb=%h hs=%b vs=%b de=%b fs=%b ls=%b ur=%b want addr=%h rgb=%h hs=%b vs=%b de=%b fs=%b ls=%b ur=%b",
                      name, $time, g.rdaddr, g.rgb, g.hs, g.vs, g.de, g.fs, g.ls, g.ur,
                      e.rdaddr, e.rgb, e.hs, e.vs, e.de, e.fs, e.ls, e.ur);
    endtask

    // One clock of stimulus: record what this cycle should show, then drive the next inputs.
    task automatic body();
        exp_q.push_back(expect_now());
        if (force_n > 0) begin
            vio.start = 1'b1;
            force_n--;
        end else vio.start = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 349) == 0) vio.line_repeat = !vio.line_repeat;
        if ($urandom_range(0, 349) == 0) vio.alt_lines = !vio.alt_lines;
        if ($urandom_range(0, 39) == 0)
            vio.wr_line = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
        model_step();
    endtask

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    initial begin
        obs_t e;
        forever begin
            @(negedge clock);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs("scan", e);
            end
        end
    end

    // Stimulus.
    initial begin
        obs_t rst_obs;
        rst_obs = '{rdaddr: 12'd0, rgb: 24'd0, hs: !HS_POL, vs: !VS_POL,
                    de: 1'b0, fs: 1'b0, ls: 1'b0, ur: 1'b0};
        vio.start = 1'b0; vio.line_repeat = 1'b0; vio.alt_lines = 1'b0; vio.wr_line = 2'd3;
        model_reset();
        repeat (3) @(negedge clock);
        #2 check_obs("reset", rst_obs);
        @(negedge clock);
        reset = 1'b1;
        force_n = 4;
        body();
        repeat (2500) begin
            @(negedge clock);
            body();
        end
        // asynchronous reset in the middle of a cycle
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_obs("mid_reset", rst_obs);
        model_reset();
        vio.line_repeat = 1'b0;
        vio.alt_lines = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        force_n = 4;
        body();
        repeat (2500) begin
            @(negedge clock);
            body();
        end
        repeat (2) @(negedge clock);
        #3;
        n_tot++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/ram2video_gen.md
# ram2video_gen

Parametrised successor of the line-buffer video scanner. Generates raster timing for any progressive mode from parameters, fetches pixels from the line-buffer RAM with a configurable read latency, and drives aligned RGB, sync and data-enable to the HDMI transmitter. Adds runtime line-repeat and alternate-line-count modes, frame/line strobes and an underrun flag. Sits between the line-buffer RAM and the video output stage.

## Interface
- ADDR_BITS, 12: RAM read address width.
- DATA_W, 24: pixel width; red/green/blue are DATA_W/3 each.
- H_VISIBLE, H_TOTAL, H_SYNC_START, H_SYNC_WIDTH: horizontal timing in clocks; H_TOTAL ≤ 4095.
- V_VISIBLE, V_TOTAL, V_TOTAL_ALT, V_SYNC_START, V_SYNC_WIDTH: vertical timing in lines; V_TOTAL_ALT is used when alt_lines=1.
- H_OFFSET, V_OFFSET, 0: fetch window inset inside the visible area.
- PIXEL_FACTOR, 1: horizontal pixel repeat (1 or 2).
- BUFFER_LINES, 4: line slots in the RAM (power of two).
- RD_LATENCY, 2: RAM read latency in clocks (1..4).
- HS_POL, VS_POL, 1: active sync level.
- clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- rddata  in  DATA_W  RAM read data, valid RD_LATENCY clocks after rdaddr.
- start  in  1  level; writer has a frame available.
- line_repeat  in  1  1 = each source line is shown twice.
- alt_lines  in  1  selects V_TOTAL_ALT.
- wr_line  in  log2(BUFFER_LINES)  slot currently being written.
- rdaddr  out  ADDR_BITS  RAM read address.
- red, green, blue  out  DATA_W/3  pixel outputs, 0 outside the draw area.
- hsync, vsync  out  1  sync outputs.
- de  out  1  draw area.
- frame_start  out  1  one-clock pulse, aligned with the first output pixel of a frame.
- line_start  out  1  one-clock pulse, aligned with the first output pixel of each line.
- underrun  out  1  sticky; set when a read targets the slot in wr_line.

## Operation
- Two states: IDLE and RUN.
- IDLE: counters held at (x=0, y=0); syncs are inactive; all other outputs are 0. Move to RUN on the first clock with start=1.
- RUN: x counts 0..H_TOTAL-1. On wrap, y counts 0..vtot-1, where vtot = alt_lines ? V_TOTAL_ALT : V_TOTAL.
- A change of line_repeat or alt_lines (sampled against a registered copy) forces IDLE on the next clock, clears underrun, and re-arms on start.
- hsync is active for H_SYNC_START ≤ x < H_SYNC_START+H_SYNC_WIDTH.
- vsync asserts at the hsync leading edge of line V_SYNC_START and deasserts at the hsync leading edge of line V_SYNC_START+V_SYNC_WIDTH.
- The fetch window is H_OFFSET ≤ x < H_VISIBLE-H_OFFSET and V_OFFSET ≤ y < V_VISIBLE-V_OFFSET. Outside the window rdaddr=0.
- Inside the window:
  - px = (x-H_OFFSET)/PIXEL_FACTOR
  - sl = line_repeat ? (y-V_OFFSET)>>1 : (y-V_OFFSET)
  - rdaddr = {sl mod BUFFER_LINES, px}, truncated to ADDR_BITS.
- underrun is set if a fetch occurs with (sl mod BUFFER_LINES) == wr_line. It is cleared only by reset or a mode change.
- de is 1 for x < H_VISIBLE and y < V_VISIBLE.
- RGB carries rddata when de=1, otherwise 0.

## Timing
- Reset values: state IDLE, counters 0, hsync=~HS_POL, vsync=~VS_POL, rgb=0, de=0, rdaddr=0, strobes=0, underrun=0.
- rdaddr is combinational from the counters.
- x/y are delayed RD_LATENCY clocks. de, RGB gating, frame_start and line_start are derived from the delayed coordinates, so de aligns with rddata.
- hsync/vsync are registered from the delayed coordinates: one further clock, i.e. RD_LATENCY+1 after the counters.
- The last line wraps to y=0 with no gap clock.
- The first active pixel appears RD_LATENCY clocks after the first RUN clock.
- Mode change and start on the same clock: the mode change wins and the block stays IDLE that clock.
- Reset mid-frame returns every output to its reset value asynchronously.

## Structure
- Package ram2video_pkg:
  - state enum (IDLE, RUN)
  - helper functions: clog2, the sync window compare
  - default timing constants for 640x480 and 720x480
- Sub-module ram2video_delay: parametrised shift register (WIDTH, DEPTH) used for the coordinate/strobe pipeline.

## Test plan
- Small mode: H_TOTAL=16, H_VISIBLE=10, H_SYNC_START=12, H_SYNC_WIDTH=2, V_TOTAL=8, V_VISIBLE=5, RD_LATENCY=2, start=1 -> hsync active on delayed x=12..13 every 16 clocks; de high 10 clocks per line for 5 lines; frame period 128 clocks.
- rddata = registered rdaddr (2 clocks) -> red/green/blue equal the expected address for each de pixel, and 0 when de=0.
- line_repeat=1, BUFFER_LINES=4 -> lines y=0,1 both read slot 0 and y=6 reads slot 3; the toggle itself forces IDLE, outputs return to reset values, and scanning restarts on start.
- alt_lines=1 with V_TOTAL_ALT=9 -> frame period 144 clocks; vsync spans exactly V_SYNC_WIDTH*16 clocks starting on an hsync leading edge.
- wr_line=1 while fetching slot 1 -> underrun rises and stays high until the next mode change.
- Assert reset mid-line -> all outputs are at reset values within the same clock; after release and start=1, the first pixel appears 2 clocks later.
